xbar_bank_arb: RTL and testbench
================================

XBAR_BANK_ARB -- requirements
Module: xbar_bank_arb

Interface
REQ-001 Parameter BANK_ID, default 0, the bank this arbiter serves; matched against request addr[9:8].
REQ-002 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-low.
REQ-004 chN_req_valid_i  input  1  channel N request valid, for each N in 0..2.
REQ-005 chN_req_allowIn_o  output  1  channel N request accepted this cycle when high together with valid.
REQ-006 chN_req_op_i  input  2  channel N opcode: 00 read, 01 write, 10/11 passed through.
REQ-007 chN_req_addr_i  input  28 (bits 31:4)  channel N line address.
REQ-008 chN_req_data_i  input  128  channel N write data.
REQ-009 htu_valid_o  output  1  registered request valid toward the bank HTU.
REQ-010 htu_allowIn_i  input  1  HTU accepts the held request when high together with htu_valid_o.
REQ-011 htu_ch_id_o  output  2  winning channel index, 0..2.
REQ-012 htu_opcode_o  output  2  held opcode.
REQ-013 htu_addr_o  output  28 (bits 31:4)  held address.
REQ-014 htu_data_o  output  128  held data.
REQ-015 htu_wbuffer_id_o  output  8  write-buffer tag for writes, 0 for non-writes.

Function
REQ-016 A channel is eligible when chN_req_valid_i=1 and chN_req_addr_i[9:8]=BANK_ID; other channels are ignored and get allowIn 0.
REQ-017 The output stage is a single register slot; slot is free when htu_valid_o=0 or (htu_valid_o & htu_allowIn_i)=1.
REQ-018 When the slot is free and at least one channel is eligible, exactly one eligible channel is granted; only its allowIn is 1; all others are 0.
REQ-019 allowIn is combinational from valid, addr, grant pointer, htu_valid_o and htu_allowIn_i; the slot loads on the same edge, giving 1-cycle latency from accept to htu_valid_o.
REQ-020 With the slot occupied and htu_allowIn_i=0, all allowIn are 0 and every htu_* output holds stable.
REQ-021 Simultaneous HTU accept and new grant: slot reloads with the new request, htu_valid_o stays 1, no bubble.
REQ-022 HTU accept with no eligible channel: htu_valid_o goes 0 next cycle.
REQ-023 Write-ID counter (8 bits) increments by 1 on each accepted op=01, wrapping 255->0; the accepted write carries the pre-increment value in htu_wbuffer_id_o.
REQ-024 Grant pointer last_grant (2 bits, values 0..2) updates to the winning index on every grant and is unchanged otherwise.

Reset
REQ-025 rst_i=0 at a clock edge sets htu_valid_o=0, write-ID counter=0, last_grant=2; htu_ch_id_o, htu_opcode_o, htu_addr_o, htu_data_o, htu_wbuffer_id_o reset to 0.
REQ-026 Reset mid-operation discards any held request; no allowIn is asserted while rst_i=0.

Configuration
REQ-027 Macro XBAR_ARB_RR_EN defined: round-robin; priority order after last_grant=k is (k+1)%3, (k+2)%3, k.
REQ-028 XBAR_ARB_RR_EN undefined: fixed priority ch0>ch1>ch2; last_grant is still maintained but does not affect selection.

Verification
REQ-029 Reset release, BANK_ID=0, ch0 valid op=00 addr[9:8]=0 -> ch0 allowIn=1 that cycle; next cycle htu_valid_o=1, ch_id=0, wbuffer_id=0.
REQ-030 RR build, ch0/1/2 all eligible continuously, htu_allowIn_i=1 -> grants ch0,ch1,ch2,ch0 on consecutive cycles, htu_valid_o constantly 1.
REQ-031 Fixed-priority build, same stimulus -> ch0 granted every cycle, ch1/ch2 allowIn stay 0.
REQ-032 ch1 eligible, htu_allowIn_i=0 for 4 cycles -> one accept, then all allowIn=0 and htu_* stable 4 cycles; accept on cycle 5 with ch1 still valid reloads with no bubble.
REQ-033 257 back-to-back writes from ch2 -> wbuffer_id sequence 0..255 then 0.
REQ-034 ch0 valid with addr[9:8]=1, BANK_ID=0 -> ch0 allowIn=0, htu_valid_o stays 0; rst_i=0 while slot full -> htu_valid_o=0 next cycle.

Source files
------------

// File: rtl/xbar_bank_arb_if.sv
// xbar_bank_arb_if: three request channels plus the registered HTU output stage
interface xbar_bank_arb_if;
  logic         ch0_req_valid_i;
  logic         ch0_req_allowIn_o;
  logic [1:0]   ch0_req_op_i;
  logic [31:4]  ch0_req_addr_i;
  logic [127:0] ch0_req_data_i;
  logic         ch1_req_valid_i;
  logic         ch1_req_allowIn_o;
  logic [1:0]   ch1_req_op_i;
  logic [31:4]  ch1_req_addr_i;
  logic [127:0] ch1_req_data_i;
  logic         ch2_req_valid_i;
  logic         ch2_req_allowIn_o;
  logic [1:0]   ch2_req_op_i;
  logic [31:4]  ch2_req_addr_i;
  logic [127:0] ch2_req_data_i;
  logic         htu_valid_o;
  logic         htu_allowIn_i;
  logic [1:0]   htu_ch_id_o;
  logic [1:0]   htu_opcode_o;
  logic [31:4]  htu_addr_o;
  logic [127:0] htu_data_o;
  logic [7:0]   htu_wbuffer_id_o;
  modport slave (
    input  ch0_req_valid_i, ch0_req_op_i, ch0_req_addr_i, ch0_req_data_i,
    input  ch1_req_valid_i, ch1_req_op_i, ch1_req_addr_i, ch1_req_data_i,
    input  ch2_req_valid_i, ch2_req_op_i, ch2_req_addr_i, ch2_req_data_i,
    input  htu_allowIn_i,
    output ch0_req_allowIn_o, ch1_req_allowIn_o, ch2_req_allowIn_o,
    output htu_valid_o, htu_ch_id_o, htu_opcode_o, htu_addr_o, htu_data_o, htu_wbuffer_id_o
  );
  modport master (
    output ch0_req_valid_i, ch0_req_op_i, ch0_req_addr_i, ch0_req_data_i,
    output ch1_req_valid_i, ch1_req_op_i, ch1_req_addr_i, ch1_req_data_i,
    output ch2_req_valid_i, ch2_req_op_i, ch2_req_addr_i, ch2_req_data_i,
    output htu_allowIn_i,
    input  ch0_req_allowIn_o, ch1_req_allowIn_o, ch2_req_allowIn_o,
    input  htu_valid_o, htu_ch_id_o, htu_opcode_o, htu_addr_o, htu_data_o, htu_wbuffer_id_o
  );
endinterface

// File: rtl/xbar_bank_arb.sv
// xbar_bank_arb: 3-channel bank arbiter into a single-slot HTU register; define XBAR_ARB_RR_EN for round-robin, fixed ch0>ch1>ch2 otherwise
module xbar_bank_arb #(
  parameter logic [1:0] BANK_ID = 2'd0
) (
  input logic clk_i,
  input logic rst_i,
  xbar_bank_arb_if.slave bus
);
  logic [2:0]        valid;
  logic [2:0][1:0]   op;
  logic [2:0][27:0]  addr;
  logic [2:0][127:0] data;
  logic [2:0]        elig;
  logic [2:0]        allow;
  logic [1:0]        win;
  logic [1:0]        last_grant;
  logic [7:0]        wid;
  logic              slot_free;
  logic              grant;
  assign valid = {bus.ch2_req_valid_i, bus.ch1_req_valid_i, bus.ch0_req_valid_i};
  assign op    = {bus.ch2_req_op_i, bus.ch1_req_op_i, bus.ch0_req_op_i};
  assign addr  = {bus.ch2_req_addr_i, bus.ch1_req_addr_i, bus.ch0_req_addr_i};
  assign data  = {bus.ch2_req_data_i, bus.ch1_req_data_i, bus.ch0_req_data_i};
  assign elig[0] = valid[0] && bus.ch0_req_addr_i[9:8] == BANK_ID;
  assign elig[1] = valid[1] && bus.ch1_req_addr_i[9:8] == BANK_ID;
  assign elig[2] = valid[2] && bus.ch2_req_addr_i[9:8] == BANK_ID;
  assign slot_free = !bus.htu_valid_o || bus.htu_allowIn_i;
  assign grant = rst_i && slot_free && |elig;
  assign allow = grant ? 3'(1) << win : 3'd0;
  assign bus.ch0_req_allowIn_o = allow[0];
  assign bus.ch1_req_allowIn_o = allow[1];
  assign bus.ch2_req_allowIn_o = allow[2];
`ifdef XBAR_ARB_RR_EN
  function automatic logic [1:0] rot(input logic [1:0] k, input logic [1:0] i);
    logic [2:0] s;
    s = {1'b0, k} + {1'b0, i};
    return s >= 3'd3 ? 2'(s - 3'd3) : s[1:0];
  endfunction
`endif
  // pick the winner; scanning from lowest to highest priority lets the best eligible overwrite
  always_comb begin
    win = 2'd0;
`ifdef XBAR_ARB_RR_EN
    for (int i = 3; i >= 1; i--)
      if (elig[rot(last_grant, 2'(i))]) win = rot(last_grant, 2'(i));
`else
    for (int i = 2; i >= 0; i--)
      if (elig[i]) win = 2'(i);
`endif
  end
  // output slot, grant pointer and write-tag counter
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bus.htu_valid_o      <= 1'b0;
      bus.htu_ch_id_o      <= 2'd0;
      bus.htu_opcode_o     <= 2'd0;
      bus.htu_addr_o       <= '0;
      bus.htu_data_o       <= '0;
      bus.htu_wbuffer_id_o <= 8'd0;
      last_grant           <= 2'd2;
      wid                  <= 8'd0;
    end else if (grant) begin
      bus.htu_valid_o      <= 1'b1;
      bus.htu_ch_id_o      <= win;
      bus.htu_opcode_o     <= op[win];
      bus.htu_addr_o       <= addr[win];
      bus.htu_data_o       <= data[win];
      bus.htu_wbuffer_id_o <= op[win] == 2'b01 ? wid : 8'd0;
      last_grant           <= win;
      wid                  <= op[win] == 2'b01 ? wid + 8'd1 : wid;
    end else if (bus.htu_allowIn_i) begin
      bus.htu_valid_o      <= 1'b0;
    end
  end
endmodule

// File: tb/tb_xbar_bank_arb.sv
// tb_xbar_bank_arb: scoreboard bench for xbar_bank_arb (BANK_ID=0), follows XBAR_ARB_RR_EN for expected arbitration
module tb_xbar_bank_arb;
  typedef struct packed {
    logic [1:0]   ch;
    logic [1:0]   op;
    logic [27:0]  addr;
    logic [127:0] data;
    logic [7:0]   wid;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0]   v = '0;
  logic [1:0]   op [3];
  logic [27:0]  addr [3];
  logic [127:0] data [3];
  logic         hready = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  ent_t q[$];
  logic       m_valid = 1'b0;
  int         m_lg = 2;
  logic [7:0] m_wid = 8'd0;
  xbar_bank_arb_if bus();
  xbar_bank_arb #(.BANK_ID(2'd0)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.ch0_req_valid_i = v[0];
  assign bus.ch1_req_valid_i = v[1];
  assign bus.ch2_req_valid_i = v[2];
  assign bus.ch0_req_op_i = op[0];
  assign bus.ch1_req_op_i = op[1];
  assign bus.ch2_req_op_i = op[2];
  assign bus.ch0_req_addr_i = addr[0];
  assign bus.ch1_req_addr_i = addr[1];
  assign bus.ch2_req_addr_i = addr[2];
  assign bus.ch0_req_data_i = data[0];
  assign bus.ch1_req_data_i = data[1];
  assign bus.ch2_req_data_i = data[2];
  assign bus.htu_allowIn_i = hready;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_ch(input int c, input logic val, input logic [1:0] o, input logic [1:0] bank);
    v[c] = val;
    op[c] = o;
    addr[c] = {$urandom, 4'h0};
    addr[c][5:4] = bank;
    data[c] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // compare at the falling edge, then advance the model to what the next rising edge must produce
  task automatic cycle();
    logic [2:0] el;
    logic [2:0] exp_allow;
    logic       free;
    int         w;
    ent_t       e;
    @(negedge clk);
    for (int c = 0; c < 3; c++) el[c] = v[c] && addr[c][5:4] == 2'd0;
    free = !m_valid || hready;
    w = -1;
`ifdef XBAR_ARB_RR_EN
    for (int j = 1; j <= 3; j++) if (w < 0 && el[(m_lg + j) % 3]) w = (m_lg + j) % 3;
`else
    for (int j = 0; j < 3; j++) if (w < 0 && el[j]) w = j;
`endif
    exp_allow = (rst && free && w >= 0) ? 3'(1 << w) : 3'b000;
    chk("allowIn", {bus.ch2_req_allowIn_o, bus.ch1_req_allowIn_o, bus.ch0_req_allowIn_o}, exp_allow);
    chk("htu_valid", bus.htu_valid_o, m_valid);
    if (m_valid) begin
      if (q.size() == 0) chk("sb_empty", 1, 0);
      else begin
        chk("htu_ch_id", bus.htu_ch_id_o, q[0].ch);
        chk("htu_opcode", bus.htu_opcode_o, q[0].op);
        chk("htu_addr", bus.htu_addr_o, q[0].addr);
        chk("htu_data", bus.htu_data_o, q[0].data);
        chk("htu_wbuf_id", bus.htu_wbuffer_id_o, q[0].wid);
        if (hready) void'(q.pop_front());
      end
    end
    if (!rst) begin
      m_valid = 1'b0;
      m_lg = 2;
      m_wid = 8'd0;
      q.delete();
    end else if (exp_allow != 0) begin
      e.ch = 2'(w);
      e.op = op[w];
      e.addr = addr[w];
      e.data = data[w];
      e.wid = op[w] == 2'b01 ? m_wid : 8'd0;
      if (op[w] == 2'b01) m_wid = m_wid + 8'd1;
      q.push_back(e);
      m_valid = 1'b1;
      m_lg = w;
    end else if (hready) m_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int c = 0; c < 3; c++) set_ch(c, 1'b0, 2'b00, 2'd0);
    set_ch(0, 1'b1, 2'b00, 2'd0);
    hready = 1'b1;
    repeat (2) cycle();
    chk("rst_ch_id", bus.htu_ch_id_o, 0);
    chk("rst_opcode", bus.htu_opcode_o, 0);
    chk("rst_addr", bus.htu_addr_o, 0);
    chk("rst_data", bus.htu_data_o, 0);
    chk("rst_wbuf_id", bus.htu_wbuffer_id_o, 0);
    rst = 1'b1;
    cycle();
    v[0] = 1'b0;
    cycle();
    cycle();
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < 3; c++) set_ch(c, 1'b1, 2'(i % 3), 2'd0);
      cycle();
    end
    for (int c = 0; c < 3; c++) set_ch(c, 1'b0, 2'b00, 2'd0);
    set_ch(0, 1'b1, 2'b00, 2'd1);
    repeat (3) cycle();
    set_ch(0, 1'b0, 2'b00, 2'd0);
    set_ch(1, 1'b1, 2'b01, 2'd0);
    hready = 1'b0;
    repeat (5) cycle();
    hready = 1'b1;
    repeat (2) cycle();
    set_ch(1, 1'b0, 2'b00, 2'd0);
    cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    for (int i = 0; i < 257; i++) begin
      set_ch(2, 1'b1, 2'b01, 2'd0);
      cycle();
    end
    set_ch(2, 1'b0, 2'b00, 2'd0);
    chk("wid_wrap", m_wid, 8'd1);
    cycle();
    for (int i = 0; i < 60; i++) begin
      for (int c = 0; c < 3; c++) set_ch(c, 1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom_range(0, 1)));
      hready = 1'($urandom_range(0, 1));
      cycle();
    end
    set_ch(0, 1'b1, 2'b01, 2'd0);
    hready = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    v = '0;
    cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
